// File: rtl/hmmm_mem_responder.sv
// Unified instruction/data memory and bus responder for the HMMM core.
// It includes a program-load port that holds the core in reset until loading completes.
module hmmm_mem_responder #(
    parameter int             DEPTH     = 256,
    parameter int             WORD_W    = 15,
    parameter logic [7:0]     PROT_BASE = 8'hF0,
    parameter int             HOLD_CYC  = 2
) (
    input  logic              ph1,
    input  logic              ph2,
    input  logic              reset,
    input  logic [7:0]        Adr,
    input  logic              MemWrite,
    inout  wire  [6:0]        Instr,
    inout  wire  [7:0]        MemData2,
    input  logic              prog_valid,
    input  logic [7:0]        prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic              prog_done,
    output logic              prog_ready,
    output logic              cpu_reset,
    output logic              wr_fault,
    output logic [7:0]        store_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYC + 1) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC);

    typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

    state_t            r_state, w_next_state;
    logic [HW-1:0]     r_hold_cnt, w_hold_cnt_next;
    logic              r_wr_fault;
    logic [7:0]        r_store_count;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_drive;
    logic              w_prog_we;
    logic              w_store_ok;
    logic              w_store_bad;
    logic [AW-1:0]     w_idx;
    logic [AW-1:0]     w_prog_idx;
    logic              w_unused_ph1;

    // ph1 only frames the read window; every state element lives on ph2.
    assign w_unused_ph1 = ph1;
    assign w_idx        = Adr[AW-1:0];
    assign w_prog_idx   = prog_addr[AW-1:0];

    always_comb begin
        w_next_state    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        prog_ready      = 1'b0;
        cpu_reset       = 1'b1;
        w_drive         = 1'b0;
        w_prog_we       = 1'b0;
        w_store_ok      = 1'b0;
        w_store_bad     = 1'b0;
        case (r_state)
            LOAD: begin
                prog_ready = 1'b1;
                w_prog_we  = prog_valid;
                if (prog_valid && prog_done) begin
                    w_next_state    = HOLD;
                    w_hold_cnt_next = '0;
                end
            end
            HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = RUN;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            RUN: begin
                cpu_reset   = 1'b0;
                w_drive     = ~MemWrite;
                w_store_ok  = MemWrite && (Adr <  PROT_BASE);
                w_store_bad = MemWrite && (Adr >= PROT_BASE);
            end
            default: w_next_state = LOAD;
        endcase
    end

    always_ff @(posedge ph2) begin
        if (reset) begin
            r_state       <= LOAD;
            r_hold_cnt    <= '0;
            r_wr_fault    <= 1'b0;
            r_store_count <= 8'h00;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_hold_cnt_next;
            if (w_store_bad) begin
                r_wr_fault <= 1'b1;
            end
            if (w_store_ok && (r_store_count != 8'hFF)) begin
                r_store_count <= r_store_count + 8'd1;
            end
        end
    end

    // Memory is never cleared; a store only replaces the low byte.
    always_ff @(posedge ph2) begin
        if (!reset) begin
            if (w_prog_we) begin
                r_mem[w_prog_idx] <= prog_data;
            end else if (w_store_ok) begin
                r_mem[w_idx][7:0] <= MemData2;
            end
        end
    end

    assign Instr       = w_drive ? r_mem[w_idx][WORD_W-1:8] : 7'bz;
    assign MemData2    = w_drive ? r_mem[w_idx][7:0]        : 8'bz;
    assign wr_fault    = r_wr_fault;
    assign store_count = r_store_count;

endmodule

// File: tb/tb_hmmm_mem_responder.sv
// Directed bench for hmmm_mem_responder: load, fetch, stores, protection, saturation, reset.
// A word-level model tracks memory and mode; literal checks pin the model.
module tb_hmmm_mem_responder;

    logic        ph1 = 1'b0;
    logic        ph2 = 1'b0;
    logic        reset;
    logic [7:0]  Adr;
    logic        MemWrite;
    wire  [6:0]  Instr;
    wire  [7:0]  MemData2;
    logic        prog_valid;
    logic [7:0]  prog_addr;
    logic [14:0] prog_data;
    logic        prog_done;
    logic        prog_ready;
    logic        cpu_reset;
    logic        wr_fault;
    logic [7:0]  store_count;

    logic [7:0]  tb_md;
    logic        tb_bus_en;

    int n_checks = 0;
    int n_errors = 0;

    // Word-level model of the responder.
    logic [14:0] m_mem [256];
    bit          m_known [256];
    bit          m_valid = 1'b0;
    bit          m_load = 1'b1;
    int          m_hold_left = 0;
    bit          m_fault = 1'b0;
    int          m_cnt = 0;
    bit          m_run;

    hmmm_mem_responder dut (
        .ph1        (ph1),
        .ph2        (ph2),
        .reset      (reset),
        .Adr        (Adr),
        .MemWrite   (MemWrite),
        .Instr      (Instr),
        .MemData2   (MemData2),
        .prog_valid (prog_valid),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_done  (prog_done),
        .prog_ready (prog_ready),
        .cpu_reset  (cpu_reset),
        .wr_fault   (wr_fault),
        .store_count(store_count)
    );

    // The bench drives the buses whenever the responder must have released them;
    // the values read back then show whether the responder stayed off the bus.
    always_comb m_run = m_valid && !m_load && (m_hold_left == 0);
    assign tb_bus_en = !m_run || MemWrite;
    assign Instr     = tb_bus_en ? 7'h00 : 7'bz;
    assign MemData2  = tb_bus_en ? (MemWrite ? tb_md : 8'h00) : 8'bz;

    initial begin
        forever begin
            ph1 = 1'b1; #8;
            ph1 = 1'b0; #2;
            ph2 = 1'b1; #8;
            ph2 = 1'b0; #2;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge ph2) begin
        if (reset) begin
            m_valid     <= 1'b1;
            m_load      <= 1'b1;
            m_hold_left <= 0;
            m_fault     <= 1'b0;
            m_cnt       <= 0;
        end else if (m_valid) begin
            if (m_load) begin
                if (prog_valid) begin
                    m_mem[prog_addr]   <= prog_data;
                    m_known[prog_addr] <= 1'b1;
                    if (prog_done) begin
                        m_load      <= 1'b0;
                        m_hold_left <= 3;
                    end
                end
            end else if (m_hold_left > 0) begin
                m_hold_left <= m_hold_left - 1;
            end else if (MemWrite) begin
                if (Adr < 8'hF0) begin
                    m_mem[Adr] <= {m_mem[Adr][14:8], tb_md};
                    m_cnt      <= (m_cnt >= 255) ? 255 : m_cnt + 1;
                end else begin
                    m_fault <= 1'b1;
                end
            end
        end
    end

    // Compare the outputs against the model in the middle of every ph1.
    always @(negedge ph1) begin
        if (m_valid) begin
            chk("prog_ready", 32'(prog_ready), 32'(m_load));
            chk("cpu_reset", 32'(cpu_reset), 32'(!m_run));
            chk("wr_fault", 32'(wr_fault), 32'(m_fault));
            chk("store_count", 32'(store_count), 32'(m_cnt));
            if (tb_bus_en) begin
                chk("bus_instr_released", 32'(Instr), 32'h00);
                chk("bus_data_released", 32'(MemData2), 32'(MemWrite ? tb_md : 8'h00));
            end else if (m_known[Adr]) begin
                chk("read_instr", 32'(Instr), 32'(m_mem[Adr][14:8]));
                chk("read_data", 32'(MemData2), 32'(m_mem[Adr][7:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ph2);
    endtask

    task automatic load_word(input logic [7:0] a, input logic [14:0] d, input logic done);
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        prog_done  = done;
        tick(1);
        prog_valid = 1'b0;
        prog_done  = 1'b0;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        Adr      = a;
        tb_md    = d;
        MemWrite = 1'b1;
        tick(1);
        MemWrite = 1'b0;
    endtask

    task automatic read_lit(input string nm, input logic [7:0] a,
                            input logic [6:0] ei, input logic [7:0] ed);
        Adr = a;
        #1;
        chk({nm, "_instr"}, 32'(Instr), 32'(ei));
        chk({nm, "_data"}, 32'(MemData2), 32'(ed));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 15'h0;
        end
        reset = 1'b1; Adr = 8'h00; MemWrite = 1'b0; tb_md = 8'h00;
        prog_valid = 1'b0; prog_addr = 8'h00; prog_data = 15'h0; prog_done = 1'b0;
        tick(2);
        reset = 1'b0;
        #1;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("rst_prog_ready", 32'(prog_ready), 32'h1);
        chk("rst_wr_fault", 32'(wr_fault), 32'h0);
        chk("rst_store_count", 32'(store_count), 32'h0);

        prog_done = 1'b1;
        tick(1);
        prog_done = 1'b0;
        #1;
        chk("done_without_valid", 32'(prog_ready), 32'h1);

        load_word(8'h10, 15'h2100, 1'b0);
        load_word(8'hF4, 15'h3355, 1'b0);
        load_word(8'h20, 15'h4400, 1'b0);
        load_word(8'h05, 15'h1111, 1'b0);
        load_word(8'h30, 15'h5A5A, 1'b0);
        load_word(8'h03, 15'h0111, 1'b0);
        load_word(8'h03, 15'h0222, 1'b0);
        load_word(8'h00, 15'h1A05, 1'b0);
        load_word(8'h01, 15'h0003, 1'b1);

        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_prog_ready", 32'(prog_ready), 32'h0);
            chk("hold_cpu_reset", 32'(cpu_reset), 32'h1);
            prog_valid = (i == 0);
            prog_addr  = 8'h30;
            prog_data  = 15'h7FFF;
            tick(1);
            prog_valid = 1'b0;
        end
        #1;
        chk("run_cpu_reset", 32'(cpu_reset), 32'h0);
        read_lit("fetch0", 8'h00, 7'h1A, 8'h05);
        read_lit("twice3", 8'h03, 7'h02, 8'h22);
        read_lit("hold_ignored", 8'h30, 7'h5A, 8'h5A);
        tick(1);

        store(8'h10, 8'h7C);
        read_lit("store_rb", 8'h10, 7'h21, 8'h7C);
        chk("store_count_1", 32'(store_count), 32'h1);
        tick(1);

        store(8'hF4, 8'hAA);
        read_lit("prot_unchanged", 8'hF4, 7'h33, 8'h55);
        chk("prot_fault", 32'(wr_fault), 32'h1);
        chk("prot_count", 32'(store_count), 32'h1);
        tick(1);
        store(8'h20, 8'h01);
        #1;
        chk("fault_sticky", 32'(wr_fault), 32'h1);
        chk("count_after_good", 32'(store_count), 32'h2);

        for (int i = 0; i < 300; i++) begin
            store(8'h20, 8'(i));
        end
        read_lit("sat_mem", 8'h20, 7'h44, 8'h2B);
        chk("sat_count", 32'(store_count), 32'hFF);
        chk("sat_fault", 32'(wr_fault), 32'h1);
        tick(1);

        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        chk("mid_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("mid_prog_ready", 32'(prog_ready), 32'h1);
        chk("mid_wr_fault", 32'(wr_fault), 32'h0);
        chk("mid_store_count", 32'(store_count), 32'h0);
        load_word(8'h05, 15'h0606, 1'b1);
        tick(3);
        #1;
        chk("reload_cpu_reset", 32'(cpu_reset), 32'h0);
        read_lit("reload5", 8'h05, 7'h06, 8'h06);
        read_lit("keep10", 8'h10, 7'h21, 8'h7C);
        read_lit("keep00", 8'h00, 7'h1A, 8'h05);
        read_lit("keep20", 8'h20, 7'h44, 8'h2B);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hmmm_mem_responder.md
# hmmm_mem_responder

Unified 256-word instruction/data memory and bus responder for the 8-bit HMMM processor core, sitting on the other end of the core's memory interface (Adr, MemWrite, Instr[14:8], MemData2[7:0]). It answers instruction fetches and loads combinationally, commits stores, and owns a program-load port. The load port fills memory while the block holds the core in reset, then releases it. A sticky fault flag and a saturating store counter support bring-up and verification.

## Interface
- DEPTH, 256: memory words; address width fixed at 8.
- WORD_W, 15: word width; bits [14:8] are the instruction high field, [7:0] the low byte.
- PROT_BASE, 8'hF0: first write-protected address; core stores to Adr >= PROT_BASE are dropped.
- HOLD_CYC, 2: cycles cpu_reset stays high after load completes.
- ph1  input  1  two-phase non-overlapping clock, phase 1.
- ph2  input  1  phase 2.
- reset  input  1  reset, synchronous, active-high.
- Adr  input  8  core address.
- MemWrite  input  1  core store strobe.
- Instr  inout  7  word bits [14:8].
- MemData2  inout  8  word bits [7:0].
- prog_valid  input  1  load-port word valid.
- prog_addr  input  8  load-port address.
- prog_data  input  15  load-port word.
- prog_done  input  1  last-word marker, sampled only with prog_valid & prog_ready.
- prog_ready  output  1  load port accepting.
- cpu_reset  output  1  drives the core's reset.
- wr_fault  output  1  sticky: protected store attempted.
- store_count  output  8  accepted core stores, saturating at 8'hFF.

## Operation
- A cycle is one ph1/ph2 pair. All state, including memory writes, is captured during ph2 and is visible from the following ph1, matching the core's flop style.
- FSM states: LOAD, HOLD, RUN.
- Reset (sampled in ph2) puts the FSM in LOAD, clears the hold counter, wr_fault and store_count. Memory contents are never cleared. Reset mid-RUN or mid-HOLD behaves the same way.
- LOAD: prog_ready=1, cpu_reset=1, bus pins tristated. Each cycle with prog_valid=1 writes mem[prog_addr]=prog_data. If prog_done=1 in the same cycle, that word is still written and the FSM goes to HOLD. A prog_done without prog_valid is ignored.
- HOLD: prog_ready=0, cpu_reset=1, bus tristated. Counts HOLD_CYC cycles, then goes to RUN. The load port is ignored.
- RUN: prog_ready=0, cpu_reset=0.
  - With MemWrite=0, the block drives Instr=mem[Adr][14:8] and MemData2=mem[Adr][7:0] combinationally.
  - With MemWrite=1, both buses are released to Z and MemData2 is sampled.
  - Store with Adr < PROT_BASE: mem[Adr][7:0]=MemData2, bits [14:8] retained, store_count increments unless already 8'hFF.
  - Store with Adr >= PROT_BASE: memory unchanged, store_count unchanged, wr_fault set.
  - MemWrite with X/Z on MemData2 is a bench error, not a design case.
- Read-during-write to the same address returns the old word in that cycle and the new word the next cycle.
- Adr is 8 bits and always in range, so there is no wrap handling. DEPTH below 256 aliases by modulo.

## Timing
- Read latency: combinational from Adr, settles within ph1 so the core's instruction latch captures it in ph2.
- Store: committed at the end of the ph2 in which MemWrite=1; visible on the next cycle's read.
- Bus turnaround: drive enable = (state==RUN) & ~MemWrite. Enable is disabled combinationally as MemWrite rises, so there is no contention cycle.
- Load handshake: one word per cycle, zero wait states. prog_ready rises in the first ph1 after reset deasserts.
- cpu_reset falls exactly 1+HOLD_CYC cycles after the cycle that accepted prog_done. The core's PC and instruction registers therefore see reset for at least HOLD_CYC full cycles.
- Reset values:
  - cpu_reset=1, prog_ready=1 (in the first ph1 after the reset cycle), wr_fault=0, store_count=0.
  - Buses are Z.

## Test plan
- Load then fetch: load mem[0]=15'h1A05, mem[1]=15'h0003 (prog_done with word 1). Require prog_ready low and cpu_reset high for 3 cycles, then low; Adr=0 returns Instr=7'h1A, MemData2=8'h05.
- Store and readback: in RUN, MemWrite=1, Adr=8'h10, MemData2=8'h7C, where mem[16] was preloaded 15'h2100. Require buses Z that cycle, then a read of 8'h10 returns 15'h217C, and store_count=1.
- Protected store: MemWrite=1, Adr=8'hF4, MemData2=8'hAA. Require mem[0xF4] unchanged, wr_fault=1 and staying 1 through later good stores, store_count unchanged.
- Counter saturation: 300 stores to Adr=8'h20 -> store_count holds 8'hFF; mem[0x20] equals the last data written.
- Reset mid-run: assert reset during RUN after stores. Require cpu_reset=1, state LOAD, wr_fault=0, store_count=0, and a subsequent load of only prog_done at addr 8'h05 preserving all other words.
- Load edge cases: prog_done asserted with prog_valid=0 -> stays in LOAD. A write to the same prog_addr twice keeps the last value. In HOLD, prog_valid=1 -> memory unchanged.
